seg_decoder: RTL and testbench
==============================

Name: seg_decoder

Overview:
- Reverse of the hex-to-7-segment encoder: takes two 7-segment patterns and recovers the 8-bit value they show.
- Main use: loopback/debug checker on the CPU board. The encoder's digito_1/digito_2 feed this block, and the bench or an on-chip monitor compares the recovered byte with the source.
- Filters transient patterns: a pattern pair is committed only after it has been stable for STABLE_CYCLES.
- Counts illegal patterns.

Parameters:
- STABLE_CYCLES, 4: consecutive unchanged comparisons required before a commit; legal range is 1 or more.
- ERRCNT_W, 8: width of the saturating error counter.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- segi_1, input, 7: low-nibble pattern, bit0 = a … bit6 = g.
- segi_2, input, 7: high-nibble pattern, same bit order.
- decodeo_data, output, 8: last committed valid byte, {hi, lo}.
- decodeo_valid, output, 1: high when the last commit was a valid pair.
- decodeo_update, output, 1: one-cycle pulse on each valid commit.
- decodeo_err, output, 1: one-cycle pulse on each invalid commit.
- decodeo_errcnt, output, ERRCNT_W: saturating count of invalid commits.

Behaviour:
- Reset: synchronous, active-high; this is fixed.
  - While rst = 1 at a clock edge, all registers clear: samp, prev, cnt, and all outputs go to 0.
  - Any pending commit is discarded; stability counting restarts on the first edge after rst falls.
- Legal patterns, nibble 0..F in order: 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F, 77, 7C, 39, 5E, 79, 71 (hex).
  - 00 is BLANK.
  - Any other value is INVALID.
- Pipeline:
  - samp <= {segi_2, segi_1} every edge.
  - prev <= samp every edge.
- Stability counter cnt, width enough to hold STABLE_CYCLES:
  - If samp != prev, then cnt <= 0.
  - Otherwise, if cnt != STABLE_CYCLES, then cnt <= cnt + 1.
  - Otherwise cnt holds (saturated).
- Commit: occurs on the edge where samp == prev and cnt == STABLE_CYCLES-1.
  - Classification uses samp; outputs are registered at that same edge.
- Latency: let the pattern first be captured into samp at edge E0.
  - E1 zeroes cnt.
  - The commit lands at edge E(1+STABLE_CYCLES): E5 for the default; E2 for STABLE_CYCLES = 1.
  - A pattern equal to the reset value (00/00) is already stable, so it commits at edge E(STABLE_CYCLES-1) after reset release.
- Commit classes:
  - Both nibbles legal: decodeo_data <= {nib2, nib1}, decodeo_valid <= 1, decodeo_update pulses.
  - Any INVALID nibble (this check takes priority): decodeo_valid <= 0, decodeo_err pulses, decodeo_errcnt increments and saturates at all-ones, decodeo_data holds.
  - Otherwise (at least one BLANK, none invalid): decodeo_valid <= 0, no pulses, decodeo_data holds.
- Only one commit per stable run: while the input is held, cnt stays saturated and no further pulses occur.
- Any change of the input pair, even for 1 cycle, restarts the run. Returning to the previously committed pair recommits it, including a fresh update pulse.
- decodeo_update and decodeo_err are mutually exclusive; both are low on every non-commit cycle.

Test Plan:
1. Reset, then hold segi_2 = 00, segi_1 = 00 for 12 cycles -> decodeo_valid = 0, update and err never pulse, errcnt = 0.
2. Hold segi_2 = 5B, segi_1 = 4F with STABLE_CYCLES = 4:
   - At edge E5: decodeo_data = 0x23, valid = 1, update high for exactly 1 cycle.
   - No further pulses over the next 20 cycles.
3. From the committed 0x23 state, drive segi_1 = 66 for 2 cycles, then back to 4F:
   - 0x24 is never committed; data stays 0x23 throughout.
   - update pulses again 5 edges after 4F is recaptured.
4. Hold segi_1 = 01 -> err pulses once, errcnt = 1, valid = 0, data remains 0x23.
5. With ERRCNT_W = 2, alternate segi_1 = 01 and 02, each held 7 cycles, 5 times -> errcnt stops at 3; err pulses 5 times.
6. Drive 71/71 for 3 cycles, assert rst for 1 cycle, keep 71/71 applied:
   - All outputs are 0 after the reset edge.
   - data = 0xFF with an update pulse at edge E(STABLE_CYCLES+1) after rst release.
   - Loopback check: feed the encoder's outputs for all 256 values, each held 8 cycles -> decodeo_data equals the source value every time, err never pulses.

Source files
------------

// File: rtl/seg_decoder.sv
// Recovers a byte from a pair of 7-segment patterns; a pair is committed only after it has
// been stable for STABLE_CYCLES comparisons, and invalid commits are counted.
module seg_decoder #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned ERRCNT_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          segi_1,
  input  logic [6:0]          segi_2,
  output logic [7:0]          decodeo_data,
  output logic                decodeo_valid,
  output logic                decodeo_update,
  output logic                decodeo_err,
  output logic [ERRCNT_W-1:0] decodeo_errcnt
);

  localparam int unsigned CntW = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax    = CntW'(STABLE_CYCLES);
  localparam logic [CntW-1:0] CntCommit = CntW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {SegBlank, SegLegal, SegInvalid} seg_kind_e;

  typedef struct packed {
    seg_kind_e  kind;
    logic [3:0] value;
  } seg_dec_t;

  function automatic seg_dec_t seg_decode(input logic [6:0] seg);
    seg_dec_t r;
    r.kind  = SegLegal;
    r.value = 4'h0;
    case (seg)
      7'h3F: r.value = 4'h0;
      7'h06: r.value = 4'h1;
      7'h5B: r.value = 4'h2;
      7'h4F: r.value = 4'h3;
      7'h66: r.value = 4'h4;
      7'h6D: r.value = 4'h5;
      7'h7D: r.value = 4'h6;
      7'h07: r.value = 4'h7;
      7'h7F: r.value = 4'h8;
      7'h6F: r.value = 4'h9;
      7'h77: r.value = 4'hA;
      7'h7C: r.value = 4'hB;
      7'h39: r.value = 4'hC;
      7'h5E: r.value = 4'hD;
      7'h79: r.value = 4'hE;
      7'h71: r.value = 4'hF;
      7'h00: r.kind  = SegBlank;
      default: r.kind = SegInvalid;
    endcase
    return r;
  endfunction

  logic [13:0]         samp_q, prev_q;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [7:0]          data_q, data_d;
  logic                valid_q, valid_d;
  logic                update_q, update_d;
  logic                err_q, err_d;
  logic [ERRCNT_W-1:0] errcnt_q, errcnt_d;

  seg_dec_t dec_lo, dec_hi;
  logic     stable, commit;

  always_comb begin
    dec_lo   = seg_decode(samp_q[6:0]);
    dec_hi   = seg_decode(samp_q[13:7]);
    stable   = (samp_q == prev_q);
    commit   = stable && (cnt_q == CntCommit);

    cnt_d    = cnt_q;
    data_d   = data_q;
    valid_d  = valid_q;
    update_d = 1'b0;
    err_d    = 1'b0;
    errcnt_d = errcnt_q;

    if (!stable) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + CntW'(1);
    end

    if (commit) begin
      // An invalid nibble wins over a blank one in the other position.
      if (dec_lo.kind == SegInvalid || dec_hi.kind == SegInvalid) begin
        valid_d = 1'b0;
        err_d   = 1'b1;
        if (errcnt_q != '1) errcnt_d = errcnt_q + ERRCNT_W'(1);
      end else if (dec_lo.kind == SegLegal && dec_hi.kind == SegLegal) begin
        data_d   = {dec_hi.value, dec_lo.value};
        valid_d  = 1'b1;
        update_d = 1'b1;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_q   <= '0;
      prev_q   <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      update_q <= 1'b0;
      err_q    <= 1'b0;
      errcnt_q <= '0;
    end else begin
      samp_q   <= {segi_2, segi_1};
      prev_q   <= samp_q;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      update_q <= update_d;
      err_q    <= err_d;
      errcnt_q <= errcnt_d;
    end
  end

  assign decodeo_data   = data_q;
  assign decodeo_valid  = valid_q;
  assign decodeo_update = update_q;
  assign decodeo_err    = err_q;
  assign decodeo_errcnt = errcnt_q;

endmodule

// File: tb/tb_seg_decoder.sv
// Directed bench for seg_decoder: default instance plus a 2-bit error-counter instance.
module tb_seg_decoder;

  localparam logic [6:0] Enc [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] segi_1 = 7'h00, segi_2 = 7'h00;
  logic [7:0] data;
  logic       valid, update, err;
  logic [7:0] errcnt;

  logic [6:0] s2_lo = 7'h00, s2_hi = 7'h00;
  logic [7:0] data2;
  logic       valid2, update2, err2;
  logic [1:0] errcnt2;

  int n_checks = 0;
  int n_errors = 0;
  int n_upd = 0, n_err = 0, n_err2 = 0;
  int snap_upd, snap_err;

  always #5 clk = ~clk;

  seg_decoder dut (
    .clk            (clk),
    .rst            (rst),
    .segi_1         (segi_1),
    .segi_2         (segi_2),
    .decodeo_data   (data),
    .decodeo_valid  (valid),
    .decodeo_update (update),
    .decodeo_err    (err),
    .decodeo_errcnt (errcnt)
  );

  seg_decoder #(.STABLE_CYCLES(4), .ERRCNT_W(2)) dut_sat (
    .clk            (clk),
    .rst            (rst),
    .segi_1         (s2_lo),
    .segi_2         (s2_hi),
    .decodeo_data   (data2),
    .decodeo_valid  (valid2),
    .decodeo_update (update2),
    .decodeo_err    (err2),
    .decodeo_errcnt (errcnt2)
  );

  // Pulse counters, sampled just after each active edge.
  always @(posedge clk) begin
    #1;
    if (update) n_upd++;
    if (err) n_err++;
    if (err2) n_err2++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // 1: reset, then a blank pair held
    tick(2);
    check("reset_data", 32'(data), 32'h0);
    check("reset_valid", 32'(valid), 32'h0);
    check("reset_errcnt", 32'(errcnt), 32'h0);
    rst = 1'b0;
    snap_upd = n_upd;
    snap_err = n_err;
    tick(12);
    check("blank_valid", 32'(valid), 32'h0);
    check("blank_no_update", 32'(n_upd - snap_upd), 32'h0);
    check("blank_no_err", 32'(n_err - snap_err), 32'h0);
    check("blank_errcnt", 32'(errcnt), 32'h0);

    // 2: 5B/4F commits 0x23 at E5
    segi_2 = 7'h5B;
    segi_1 = 7'h4F;
    tick(5);
    check("pre_commit_update", 32'(update), 32'h0);
    check("pre_commit_valid", 32'(valid), 32'h0);
    tick(1);
    check("commit_data", 32'(data), 32'h23);
    check("commit_valid", 32'(valid), 32'h1);
    check("commit_update", 32'(update), 32'h1);
    tick(1);
    check("update_one_cycle", 32'(update), 32'h0);
    snap_upd = n_upd;
    tick(20);
    check("held_no_repulse", 32'(n_upd - snap_upd), 32'h0);

    // 3: 2-cycle glitch to 66, then back to 4F
    segi_1 = 7'h66;
    tick(2);
    check("glitch_data", 32'(data), 32'h23);
    segi_1 = 7'h4F;
    snap_upd = n_upd;
    tick(5);
    check("recommit_early", 32'(update), 32'h0);
    check("recommit_data_hold", 32'(data), 32'h23);
    tick(1);
    check("recommit_update", 32'(update), 32'h1);
    check("recommit_data", 32'(data), 32'h23);
    tick(4);
    check("recommit_count", 32'(n_upd - snap_upd), 32'h1);
    check("no_err_so_far", 32'(n_err - snap_err), 32'h0);

    // 4: invalid low nibble
    segi_1 = 7'h01;
    snap_err = n_err;
    tick(6);
    check("invalid_err", 32'(err), 32'h1);
    check("invalid_errcnt", 32'(errcnt), 32'h1);
    check("invalid_valid", 32'(valid), 32'h0);
    check("invalid_data_hold", 32'(data), 32'h23);
    tick(10);
    check("invalid_single_pulse", 32'(n_err - snap_err), 32'h1);

    // 5: saturation of a 2-bit error counter
    s2_hi = 7'h3F;
    for (int i = 0; i < 5; i++) begin
      s2_lo = (i % 2 == 0) ? 7'h01 : 7'h02;
      tick(7);
      check("sat_errcnt", 32'(errcnt2), (i < 3) ? 32'(i + 1) : 32'h3);
    end
    check("sat_err_pulses", 32'(n_err2), 32'h5);
    check("sat_valid", 32'(valid2), 32'h0);

    // 6: reset while 71/71 applied
    segi_2 = 7'h71;
    segi_1 = 7'h71;
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("rst_data", 32'(data), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_update", 32'(update), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_errcnt", 32'(errcnt), 32'h0);
    tick(5);
    check("ff_early", 32'(update), 32'h0);
    tick(1);
    check("ff_data", 32'(data), 32'hFF);
    check("ff_valid", 32'(valid), 32'h1);
    check("ff_update", 32'(update), 32'h1);

    // Loopback over all byte values
    snap_upd = n_upd;
    snap_err = n_err;
    for (int v = 0; v < 256; v++) begin
      segi_2 = Enc[v / 16];
      segi_1 = Enc[v % 16];
      tick(8);
      check("loop_data", 32'(data), 32'(v));
    end
    check("loop_valid", 32'(valid), 32'h1);
    check("loop_updates", 32'(n_upd - snap_upd), 32'd256);
    check("loop_no_err", 32'(n_err - snap_err), 32'h0);
    check("loop_errcnt", 32'(errcnt), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
